// File: rtl/spi_target_shift_pkg.sv
// Shared constants, state type and bit-position helpers for the SPI target shift engine.
package spi_target_shift_pkg;

    localparam int unsigned MAX_CHAR      = 32;
    localparam int unsigned CHAR_LEN_BITS = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Number of bits in a character; len=0 encodes the full MAX_CHAR width.
    function automatic logic [CHAR_LEN_BITS:0] char_count(
        input logic [CHAR_LEN_BITS-1:0] len
    );
        return (len == '0) ? (CHAR_LEN_BITS+1)'(MAX_CHAR)
                           : {1'b0, len} + (CHAR_LEN_BITS+1)'(1);
    endfunction

    // Register index of the bit handled while cnt bits remain in the character.
    // MSB-first walks down from len to 0, LSB-first walks up from 0 to len.
    function automatic logic [CHAR_LEN_BITS-1:0] bit_pos(
        input logic [CHAR_LEN_BITS-1:0] len,
        input logic                     lsb,
        input logic [CHAR_LEN_BITS:0]   cnt
    );
        return lsb ? CHAR_LEN_BITS'(char_count(len) - cnt)
                   : CHAR_LEN_BITS'(cnt - (CHAR_LEN_BITS+1)'(1));
    endfunction

endpackage

// File: rtl/spi_target_shift_sync_edge.sv
// Two-flop synchroniser with a history flop, producing single-clk rise/fall pulses.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic hist_q;

    // Bring the pin into the clk domain and keep one cycle of history
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= RESET_VAL;
            s2_q   <= RESET_VAL;
            hist_q <= RESET_VAL;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            hist_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~hist_q;
    assign fall_o = ~s2_q & hist_q;

endmodule

// File: rtl/spi_target_shift.sv
// SPI target-side shift engine: deserialises MOSI, serialises a preloaded word on MISO.
module spi_target_shift #(
    parameter int unsigned MAX_CHAR      = spi_target_shift_pkg::MAX_CHAR,
    parameter int unsigned CHAR_LEN_BITS = spi_target_shift_pkg::CHAR_LEN_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHAR_LEN_BITS-1:0] len,
    input  logic                     lsb,
    input  logic                     rx_negedge,
    input  logic                     tx_negedge,
    input  logic [MAX_CHAR-1:0]      tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [MAX_CHAR-1:0]      rx_data,
    output logic                     rx_valid,
    output logic                     busy,
    output logic                     underrun,
    output logic                     abort,
    input  logic                     sclk,
    input  logic                     cs_n,
    input  logic                     mosi,
    output logic                     miso,
    output logic                     miso_oe
);

    import spi_target_shift_pkg::*;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic mosi_s1_q, mosi_s2_q;

    state_t                   state_q, state_d;
    logic [CHAR_LEN_BITS:0]   cnt_q, cnt_d;
    logic [MAX_CHAR-1:0]      tx_q, tx_d;
    logic [MAX_CHAR-1:0]      rx_q, rx_d;
    logic [MAX_CHAR-1:0]      rx_data_q, rx_data_d;
    logic                     tx_loaded_q, tx_loaded_d;
    logic                     done_q, done_d;
    logic                     und_pend_q, und_pend_d;
    logic                     drv_q, drv_d;
    logic [CHAR_LEN_BITS-1:0] len_q, len_d;
    logic                     lsb_q, lsb_d;
    logic                     rxneg_q, rxneg_d;
    logic                     txneg_q, txneg_d;
    logic                     miso_q, miso_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     tx_ready_q, tx_ready_d;
    logic                     underrun_q, underrun_d;
    logic                     abort_q, abort_d;

    logic [CHAR_LEN_BITS:0]   chars_in, chars_q;
    logic                     sample_ev, drive_ev;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (cs_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // MOSI only needs the level, aligned with the SCLK edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign chars_in  = char_count(len);
    assign chars_q   = char_count(len_q);
    assign sample_ev = rxneg_q ? sclk_fall : sclk_rise;
    assign drive_ev  = txneg_q ? sclk_fall : sclk_rise;

    // Next-state logic: completion, then sample, then drive, then CS_n release
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rx_data_d   = rx_data_q;
        tx_loaded_d = tx_loaded_q;
        done_d      = 1'b0;
        und_pend_d  = und_pend_q;
        drv_d       = drv_q;
        len_d       = len_q;
        lsb_d       = lsb_q;
        rxneg_d     = rxneg_q;
        txneg_d     = txneg_q;
        miso_d      = miso_q;
        rx_valid_d  = 1'b0;
        tx_ready_d  = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;

        // Publish the character whose last bit was sampled on the previous clk;
        // this also runs in IDLE when CS_n rose together with that last sample.
        if (done_q) begin
            rx_data_d  = rx_q;
            rx_valid_d = 1'b1;
            rx_d       = '0;
            drv_d      = 1'b0;
            cnt_d      = (state_q == ACTIVE) ? chars_q : '0;
            if (tx_valid) begin
                tx_d        = tx_data;
                tx_loaded_d = 1'b1;
                tx_ready_d  = 1'b1;
                und_pend_d  = 1'b0;
            end else begin
                tx_d        = '0;
                tx_loaded_d = 1'b0;
                und_pend_d  = (state_q == ACTIVE);
            end
        end

        if (state_q == IDLE) begin
            len_d   = len;
            lsb_d   = lsb;
            rxneg_d = rx_negedge;
            txneg_d = tx_negedge;
            if (cs_fall) begin
                state_d    = ACTIVE;
                cnt_d      = chars_in;
                rx_d       = '0;
                und_pend_d = 1'b0;
                if (tx_loaded_d) begin
                    miso_d = tx_d[bit_pos(len, lsb, chars_in)];
                    drv_d  = 1'b1;
                end else begin
                    tx_d       = '0;
                    miso_d     = 1'b0;
                    underrun_d = 1'b1;
                end
            end else if (!done_q && !tx_loaded_q && tx_valid) begin
                tx_d        = tx_data;
                tx_loaded_d = 1'b1;
                tx_ready_d  = 1'b1;
            end
        end else begin
            if (sample_ev && cnt_d != '0) begin
                rx_d[bit_pos(len_q, lsb_q, cnt_d)] = mosi_s2_q;
                cnt_d = cnt_d - (CHAR_LEN_BITS+1)'(1);
                if (cnt_d == '0) begin
                    done_d = 1'b1;
                end
            end
            // With equal edge polarities no separate drive edge precedes the next
            // sample, so the next character's first bit goes out on completion.
            if ((drive_ev || (done_q && rxneg_q == txneg_q)) && cnt_d != '0) begin
                miso_d = tx_d[bit_pos(len_q, lsb_q, cnt_d)];
                if (und_pend_d) begin
                    underrun_d = 1'b1;
                    und_pend_d = 1'b0;
                end else if (tx_loaded_d) begin
                    drv_d = 1'b1;
                end
            end
            if (cs_rise) begin
                state_d    = IDLE;
                miso_d     = 1'b0;
                und_pend_d = 1'b0;
                if (cnt_d != chars_q && cnt_d != '0) begin
                    abort_d = 1'b1;
                end
                if (!done_d) begin
                    rx_d = '0;
                end
                if (drv_d) begin
                    tx_loaded_d = 1'b0;
                end
                drv_d = 1'b0;
                cnt_d = '0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rx_data_q   <= '0;
            tx_loaded_q <= 1'b0;
            done_q      <= 1'b0;
            und_pend_q  <= 1'b0;
            drv_q       <= 1'b0;
            len_q       <= '0;
            lsb_q       <= 1'b0;
            rxneg_q     <= 1'b0;
            txneg_q     <= 1'b0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rx_data_q   <= rx_data_d;
            tx_loaded_q <= tx_loaded_d;
            done_q      <= done_d;
            und_pend_q  <= und_pend_d;
            drv_q       <= drv_d;
            len_q       <= len_d;
            lsb_q       <= lsb_d;
            rxneg_q     <= rxneg_d;
            txneg_q     <= txneg_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign busy     = (state_q == ACTIVE);
    assign miso_oe  = busy;
    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;
    assign underrun = underrun_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_spi_target_shift.sv
// Directed bench for spi_target_shift: a mode-0 SPI master at clk/8 with hand-computed expectations.
`timescale 1ns/1ps
module tb_spi_target_shift;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  len;
    logic        lsb, rx_negedge, tx_negedge;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, busy, underrun, abort;
    logic        sclk, cs_n, mosi;
    logic        miso, miso_oe;

    int n_rxv = 0, n_txr = 0, n_und = 0, n_abt = 0;
    int b_rxv, b_txr, b_und, b_abt;
    int errors = 0;
    int checks = 0;
    logic [31:0] win;

    always #5 clk = ~clk;

    spi_target_shift dut (
        .clk        (clk),
        .rst        (rst),
        .len        (len),
        .lsb        (lsb),
        .rx_negedge (rx_negedge),
        .tx_negedge (tx_negedge),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .underrun   (underrun),
        .abort      (abort),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe)
    );

    // Count single-cycle pulses midway between active edges
    always @(negedge clk) begin
        if (rx_valid) n_rxv++;
        if (tx_ready) n_txr++;
        if (underrun) n_und++;
        if (abort)    n_abt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic snap();
        b_rxv = n_rxv;
        b_txr = n_txr;
        b_und = n_und;
        b_abt = n_abt;
    endtask

    task automatic preload(input logic [31:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic cs_assert();
        cs_n = 1'b0;
        half();
    endtask

    // Leaves SCLK high after the last bit so the next call starts with a falling edge
    task automatic shift_bits(input int nbits, input logic [31:0] wout, input bit lsbf,
                              output logic [31:0] wget);
        int k;
        wget = '0;
        for (int i = 0; i < nbits; i++) begin
            k = lsbf ? i : nbits - 1 - i;
            if (sclk) sclk = 1'b0;
            mosi = wout[k];
            half();
            sclk = 1'b1;
            wget[k] = miso;
            half();
        end
    endtask

    task automatic cs_release();
        cs_n = 1'b1;
        half();
        sclk = 1'b0;
        half();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        len = 5'd7; lsb = 1'b0; rx_negedge = 1'b0; tx_negedge = 1'b1;
        tx_data = '0; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_data, 32'h0);
        check("reset_flags", 32'({rx_valid, tx_ready, busy, underrun, abort, miso, miso_oe}), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0, MSB first, 8 bits
        snap();
        preload(32'hA5);
        check("t1_tx_ready", 32'(n_txr - b_txr), 32'd1);
        cs_assert();
        check("t1_busy", 32'({busy, miso_oe}), 32'h3);
        shift_bits(8, 32'h3C, 1'b0, win);
        cs_release();
        check("t1_rx_data", rx_data, 32'h0000003C);
        check("t1_rx_valid", 32'(n_rxv - b_rxv), 32'd1);
        check("t1_miso", win, 32'hA5);
        check("t1_underrun", 32'(n_und - b_und), 32'd0);
        check("t1_idle", 32'({busy, miso_oe, miso}), 32'h0);

        // LSB first, 32 bits (len=0)
        len = 5'd0; lsb = 1'b1;
        snap();
        preload(32'hDEADBEEF);
        cs_assert();
        shift_bits(32, 32'h12345678, 1'b1, win);
        cs_release();
        check("t2_rx_data", rx_data, 32'h12345678);
        check("t2_miso", win, 32'hDEADBEEF);
        check("t2_rx_valid", 32'(n_rxv - b_rxv), 32'd1);

        // Back-to-back characters under one CS_n
        len = 5'd7; lsb = 1'b0;
        snap();
        preload(32'h11);
        tx_data = 32'h22; tx_valid = 1'b1;
        cs_assert();
        shift_bits(8, 32'h5A, 1'b0, win);
        repeat (2) @(negedge clk);
        check("t3_rx_data0", rx_data, 32'h5A);
        check("t3_miso0", win, 32'h11);
        tx_valid = 1'b0;
        shift_bits(8, 32'hC3, 1'b0, win);
        cs_release();
        check("t3_rx_data1", rx_data, 32'hC3);
        check("t3_miso1", win, 32'h22);
        check("t3_rx_valid", 32'(n_rxv - b_rxv), 32'd2);
        check("t3_tx_ready", 32'(n_txr - b_txr), 32'd2);
        check("t3_underrun", 32'(n_und - b_und), 32'd0);

        // Abort after 3 of 8 bits
        snap();
        preload(32'h96);
        cs_assert();
        shift_bits(3, 32'h5, 1'b0, win);
        cs_release();
        check("t4_miso", win, 32'h4);
        check("t4_abort", 32'(n_abt - b_abt), 32'd1);
        check("t4_rx_valid", 32'(n_rxv - b_rxv), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_rx_data", rx_data, 32'hC3);

        // Underrun: nothing loaded
        snap();
        cs_assert();
        shift_bits(8, 32'hE7, 1'b0, win);
        cs_release();
        check("t5_underrun", 32'(n_und - b_und), 32'd1);
        check("t5_miso", win, 32'h0);
        check("t5_rx_data", rx_data, 32'hE7);
        check("t5_rx_valid", 32'(n_rxv - b_rxv), 32'd1);
        check("t5_tx_ready", 32'(n_txr - b_txr), 32'd0);

        // Reset after bit 5, then a clean transfer
        snap();
        preload(32'h81);
        cs_assert();
        shift_bits(5, 32'h1F, 1'b0, win);
        rst = 1'b1;
        #1;
        check("t6_rst_rx_data", rx_data, 32'h0);
        check("t6_rst_flags", 32'({rx_valid, tx_ready, busy, underrun, abort, miso, miso_oe}), 32'h0);
        cs_n = 1'b1; sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_no_pulses", 32'((n_rxv - b_rxv) + (n_abt - b_abt)), 32'd0);
        snap();
        preload(32'hC3);
        check("t6_tx_ready", 32'(n_txr - b_txr), 32'd1);
        cs_assert();
        shift_bits(8, 32'h99, 1'b0, win);
        cs_release();
        check("t6_rx_data", rx_data, 32'h99);
        check("t6_miso", win, 32'hC3);
        check("t6_rx_valid", 32'(n_rxv - b_rxv), 32'd1);
        check("t6_underrun", 32'(n_und - b_und), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
